// File: rtl/instruction_decoder.sv
// Byte-serial 6502-style instruction decoder: IDLE -> (OPERAND) -> EXECUTE -> NEXT.
// Optional macro INSTRUCTION_DECODER_TRANSFER_EN adds decoding of TAX/TXA/TAY/TYA.
module instruction_decoder #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instruction_ready,
    input  logic [REG_WIDTH-1:0]  instruction_in,
    input  logic [ADDR_WIDTH-1:0] address_in,
    output logic [7:0]            opp,
    output logic [6:0]            we,
    output logic [2:0]            source_selector_0,
    output logic [2:0]            source_selector_1,
    output logic [2:0]            target_selector_0,
    output logic [2:0]            target_selector_1,
    output logic [REG_WIDTH-1:0]  imm_addr,
    output logic                  get_next
);
    typedef enum logic [1:0] {IDLE, OPERAND, EXECUTE, NEXT} state_t;

    localparam logic [2:0] SRC_ZERO = 3'd6;
    localparam logic [2:0] TGT_NONE = 3'd4;

    state_t               state_reg, state_next;
    logic [7:0]           opp_reg;
    logic [REG_WIDTH-1:0] imm_reg;
    logic                 operand_req_reg;
    logic                 two_byte;
    logic [6:0]           dec_we;
    logic [2:0]           dec_src, dec_tgt;
    logic                 unused_inputs;

    // The fetch address is not needed for decoding.
    assign unused_inputs = ^address_in;

    always_comb begin
        case (instruction_in[7:0])
            8'hA9, 8'h85, 8'hA2, 8'hA0, 8'h86, 8'h84: two_byte = 1'b1;
            default:                                  two_byte = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            opp_reg         <= '0;
            imm_reg         <= '0;
            operand_req_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            operand_req_reg <= (state_reg == IDLE) && instruction_ready && two_byte;
            if (state_reg == IDLE && instruction_ready)
                opp_reg <= instruction_in[7:0];
            if (state_reg == OPERAND && instruction_ready)
                imm_reg <= instruction_in;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (instruction_ready) state_next = two_byte ? OPERAND : EXECUTE;
            OPERAND: if (instruction_ready) state_next = EXECUTE;
            EXECUTE: state_next = NEXT;
            NEXT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Opcode table; selector pair 1 stays parked for the future ALU operand B.
    always_comb begin
        dec_we  = 7'd0;
        dec_src = SRC_ZERO;
        dec_tgt = TGT_NONE;
        case (opp_reg)
            8'hA9: begin dec_src = 3'd4; dec_tgt = 3'd1; dec_we = 7'b0000100; end
            8'h85: begin dec_src = 3'd1; dec_tgt = 3'd5; dec_we = 7'b1000000; end
            8'hA2: begin dec_src = 3'd4; dec_tgt = 3'd2; dec_we = 7'b0001000; end
            8'hA0: begin dec_src = 3'd4; dec_tgt = 3'd3; dec_we = 7'b0010000; end
            8'h86: begin dec_src = 3'd2; dec_tgt = 3'd5; dec_we = 7'b1000000; end
            8'h84: begin dec_src = 3'd3; dec_tgt = 3'd5; dec_we = 7'b1000000; end
`ifdef INSTRUCTION_DECODER_TRANSFER_EN
            8'hAA: begin dec_src = 3'd1; dec_tgt = 3'd2; dec_we = 7'b0001000; end
            8'h8A: begin dec_src = 3'd2; dec_tgt = 3'd1; dec_we = 7'b0000100; end
            8'hA8: begin dec_src = 3'd1; dec_tgt = 3'd3; dec_we = 7'b0010000; end
            8'h98: begin dec_src = 3'd3; dec_tgt = 3'd1; dec_we = 7'b0000100; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        we                = 7'd0;
        source_selector_0 = SRC_ZERO;
        source_selector_1 = SRC_ZERO;
        target_selector_0 = TGT_NONE;
        target_selector_1 = TGT_NONE;
        if (state_reg == EXECUTE) begin
            we                = dec_we;
            source_selector_0 = dec_src;
            target_selector_0 = dec_tgt;
        end
        // Operand request pulses once on entry to OPERAND; NEXT requests the next opcode.
        get_next = (state_reg == NEXT) || operand_req_reg;
        opp      = opp_reg;
        imm_addr = imm_reg;
    end
endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder: per-cycle expectation schedule built from the opcode table.
// Build with +define+INSTRUCTION_DECODER_TRANSFER_EN to exercise the transfer opcodes.
module tb_instruction_decoder;
    localparam int N = 512;

    logic        clk;
    logic        reset;
    logic        instruction_ready;
    logic [7:0]  instruction_in;
    logic [15:0] address_in;
    logic [7:0]  opp;
    logic [6:0]  we;
    logic [2:0]  source_selector_0, source_selector_1;
    logic [2:0]  target_selector_0, target_selector_1;
    logic [7:0]  imm_addr;
    logic        get_next;

    instruction_decoder #(.REG_WIDTH(8), .ADDR_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .instruction_ready(instruction_ready), .instruction_in(instruction_in),
        .address_in(address_in), .opp(opp), .we(we),
        .source_selector_0(source_selector_0), .source_selector_1(source_selector_1),
        .target_selector_0(target_selector_0), .target_selector_1(target_selector_1),
        .imm_addr(imm_addr), .get_next(get_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int vectors = 0;
    int fails   = 0;

    // Expected outputs for each cycle index
    logic [7:0] exp_opp[N];
    logic [7:0] exp_imm[N];
    logic [6:0] exp_we[N];
    logic [2:0] exp_src[N];
    logic [2:0] exp_tgt[N];
    logic       exp_gn[N];

    logic [6:0] cap_we;
    logic [2:0] cap_src, cap_tgt;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Reference opcode table: length, write enable, source, target
    function automatic void ref_dec(input logic [7:0] op, output int len,
                                    output logic [6:0] w, output logic [2:0] s, output logic [2:0] t);
        len = 1; w = 7'd0; s = 3'd6; t = 3'd4;
        case (op)
            8'hA9: begin len = 2; s = 3'd4; t = 3'd1; w = 7'd1 << 2; end
            8'h85: begin len = 2; s = 3'd1; t = 3'd5; w = 7'd1 << 6; end
            8'hA2: begin len = 2; s = 3'd4; t = 3'd2; w = 7'd1 << 3; end
            8'hA0: begin len = 2; s = 3'd4; t = 3'd3; w = 7'd1 << 4; end
            8'h86: begin len = 2; s = 3'd2; t = 3'd5; w = 7'd1 << 6; end
            8'h84: begin len = 2; s = 3'd3; t = 3'd5; w = 7'd1 << 6; end
`ifdef INSTRUCTION_DECODER_TRANSFER_EN
            8'hAA: begin s = 3'd1; t = 3'd2; w = 7'd1 << 3; end
            8'h8A: begin s = 3'd2; t = 3'd1; w = 7'd1 << 2; end
            8'hA8: begin s = 3'd1; t = 3'd3; w = 7'd1 << 4; end
            8'h98: begin s = 3'd3; t = 3'd1; w = 7'd1 << 2; end
`endif
            default: ;
        endcase
    endfunction

    task automatic tail_opp(input int c, input logic [7:0] v);
        for (int i = c; i < N; i++) exp_opp[i] = v;
    endtask

    task automatic tail_imm(input int c, input logic [7:0] v);
        for (int i = c; i < N; i++) exp_imm[i] = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed one instruction; operand arrives 'gap' cycles after the operand request.
    // With 'junk' set, ready stays high with a bogus byte through EXECUTE and NEXT.
    task automatic send(input logic [7:0] op, input logic [7:0] operand, input int gap, input bit junk);
        int len, a, e;
        logic [6:0] w;
        logic [2:0] s, t;
        ref_dec(op, len, w, s, t);
        a = cyc;
        instruction_ready = 1'b1;
        instruction_in    = op;
        address_in        = address_in + 16'd1;
        tail_opp(a + 1, op);
        if (len == 2) begin
            exp_gn[a + 1] = 1'b1;
            step();
            instruction_ready = 1'b0;
            instruction_in    = 8'h00;
            repeat (gap) step();
            instruction_ready = 1'b1;
            instruction_in    = operand;
            address_in        = address_in + 16'd1;
            e = cyc + 1;
            tail_imm(e, operand);
        end else begin
            e = a + 1;
        end
        exp_we[e]     = w;
        exp_src[e]    = s;
        exp_tgt[e]    = t;
        exp_gn[e + 1] = 1'b1;
        step();
        instruction_ready = junk;
        instruction_in    = 8'hA9;
        cap_we  = we;
        cap_src = source_selector_0;
        cap_tgt = target_selector_0;
        step();
        step();
        instruction_ready = 1'b0;
        instruction_in    = 8'h00;
    endtask

    // Per-cycle compare against the schedule
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < N) begin
            chk("opp", opp, exp_opp[cyc]);
            chk("imm_addr", imm_addr, exp_imm[cyc]);
            chk("we", we, exp_we[cyc]);
            chk("src0", source_selector_0, exp_src[cyc]);
            chk("tgt0", target_selector_0, exp_tgt[cyc]);
            chk("src1", source_selector_1, 6);
            chk("tgt1", target_selector_1, 4);
            chk("get_next", get_next, exp_gn[cyc]);
            chk("we_onehot", ($countones(we) <= 1) ? 1 : 0, 1);
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            exp_opp[i] = 8'h00; exp_imm[i] = 8'h00; exp_we[i] = 7'd0;
            exp_src[i] = 3'd6;  exp_tgt[i] = 3'd4;  exp_gn[i] = 1'b0;
        end
        reset = 1'b1;
        instruction_ready = 1'b0;
        instruction_in = 8'h00;
        address_in = 16'h0200;
        step();
        step();
        reset = 1'b0;
        step();

        send(8'hA9, 8'h04, 1, 1'b0);
        chk("lda_imm", imm_addr, 8'h04);
        chk("lda_we", cap_we, 7'b0000100);
        chk("lda_src", cap_src, 4);
        chk("lda_tgt", cap_tgt, 1);

        send(8'h85, 8'h02, 1, 1'b0);
        chk("sta_imm", imm_addr, 8'h02);
        chk("sta_we", cap_we, 7'b1000000);
        chk("sta_tgt", cap_tgt, 5);

        send(8'h00, 8'h00, 0, 1'b0);
        chk("brk_we", cap_we, 7'd0);
        send(8'hEA, 8'h00, 0, 1'b1);
        chk("nop_opp", opp, 8'hEA);

        send(8'hA9, 8'h7F, 4, 1'b0);
        chk("wait_imm", imm_addr, 8'h7F);

        send(8'hA2, 8'h11, 1, 1'b1);
        send(8'hA0, 8'h22, 2, 1'b0);
        send(8'h86, 8'h33, 1, 1'b0);
        send(8'h84, 8'h44, 1, 1'b0);
        send(8'hFF, 8'h00, 0, 1'b0);

        send(8'hAA, 8'h00, 0, 1'b0);
`ifdef INSTRUCTION_DECODER_TRANSFER_EN
        chk("tax_we", cap_we, 7'b0001000);
        chk("tax_src", cap_src, 1);
        chk("tax_tgt", cap_tgt, 2);
`else
        chk("tax_we", cap_we, 7'd0);
        chk("tax_src", cap_src, 6);
        chk("tax_tgt", cap_tgt, 4);
`endif
        send(8'h8A, 8'h00, 0, 1'b0);
        send(8'hA8, 8'h00, 0, 1'b1);
        send(8'h98, 8'h00, 0, 1'b0);

        // Reset in the middle of waiting for an operand
        instruction_ready = 1'b1;
        instruction_in    = 8'h85;
        tail_opp(cyc + 1, 8'h85);
        exp_gn[cyc + 1] = 1'b1;
        step();
        instruction_ready = 1'b0;
        step();
        #1;
        reset = 1'b1;
        tail_opp(cyc, 8'h00);
        tail_imm(cyc, 8'h00);
        #1;
        chk("rst_opp", opp, 8'h00);
        chk("rst_imm", imm_addr, 8'h00);
        chk("rst_we", we, 7'd0);
        chk("rst_src0", source_selector_0, 6);
        chk("rst_tgt0", target_selector_0, 4);
        chk("rst_gn", get_next, 0);
        step();
        step();
        reset = 1'b0;
        repeat (4) step();

        send(8'hA0, 8'h5A, 1, 1'b0);
        chk("post_rst_imm", imm_addr, 8'h5A);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/instruction_decoder.md
INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 Parameter: REG_WIDTH, 8, data/instruction byte width.
REQ-002 Parameter: ADDR_WIDTH, 16, address width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  asynchronous reset, active high.
REQ-006 Port: instruction_ready  in  1  instruction_in/address_in valid this cycle.
REQ-007 Port: instruction_in  in  REG_WIDTH  opcode or operand byte from fetcher.
REQ-008 Port: address_in  in  ADDR_WIDTH  address the byte was fetched from.
REQ-009 Port: opp  out  8  latched opcode of current instruction.
REQ-010 Port: we  out  7  write enables: [0]PC [1]SP [2]ADD [3]X [4]Y [5]STAT [6]DOUT (memory).
REQ-011 Port: source_selector_0 / source_selector_1  out  3 each  mux select: 0 PC, 1 ADD, 2 X, 3 Y, 4 imm, 5 mem, 6 zero, 7 fetch.
REQ-012 Port: target_selector_0 / target_selector_1  out  3 each  fan select: 0 PC, 1 ADD, 2 X, 3 Y, 4 none, 5 mem-in, 6 ALU, 7 fetch.
REQ-013 Port: imm_addr  out  REG_WIDTH  latched operand (immediate value or zero-page address).
REQ-014 Port: get_next  out  1  one-cycle request for the next byte.

Function
REQ-015 States: IDLE, OPERAND, EXECUTE, NEXT.
- IDLE: on instruction_ready=1, latch instruction_in into opp.
- 2-byte opcode -> OPERAND, get_next=1 for the next cycle.
- Otherwise -> EXECUTE.
REQ-016 OPERAND: on instruction_ready=1, latch instruction_in into imm_addr, then -> EXECUTE; while instruction_ready=0, hold.
REQ-017 EXECUTE lasts exactly one cycle and drives the opcode's selectors and we; all other cycles drive we=0 and all selectors=6 (source) / 4 (target).
REQ-018 NEXT: get_next=1 for one cycle, then -> IDLE.
REQ-019 Latency: 1-byte instruction is 3 cycles from opcode accept to get_next; 2-byte instruction is 3 cycles after operand accept.
REQ-020 Opcode A9 (LDA #imm): 2-byte; EXECUTE source_0=4, target_0=1, we[2]=1.
REQ-021 Opcode 85 (STA zpg): 2-byte; EXECUTE source_0=1, target_0=5, we[6]=1; imm_addr holds the target address.
REQ-022 Opcode A2 (LDX #imm) / A0 (LDY #imm): 2-byte; source_0=4, target_0=2 / 3, we[3] / we[4]=1.
REQ-023 Opcode 86 (STX zpg) / 84 (STY zpg): 2-byte; source_0=2 / 3, target_0=5, we[6]=1.
REQ-024 Opcode EA and any unlisted opcode, including 00: 1-byte no-op; EXECUTE asserts no we bit.
REQ-025 Selector pair 1 SHALL be 6/4 for all listed opcodes; it is reserved for ALU operand B.
REQ-026 instruction_ready in EXECUTE or NEXT SHALL be ignored; no byte is lost because the fetcher holds it until get_next.
REQ-027 At most one we bit SHALL be high in any cycle.

Reset
REQ-028 While reset=1, and immediately on its assertion: state=IDLE, opp=00, imm_addr=00, we=0, get_next=0, source selectors=6, target selectors=4.
REQ-029 Reset mid-instruction SHALL abandon the instruction with no write issued.

Configuration
REQ-030 Macro INSTRUCTION_DECODER_TRANSFER_EN: when defined, 1-byte transfers are decoded in EXECUTE as follows.
- AA TAX: src 1 -> tgt 2, we[3].
- 8A TXA: src 2 -> tgt 1, we[2].
- A8 TAY: src 1 -> tgt 3, we[4].
- 98 TYA: src 3 -> tgt 1, we[2].
When undefined, these opcodes decode as no-ops per REQ-024.

Verification
REQ-031 Reset asserted mid-OPERAND -> all outputs at REQ-028 values asynchronously; no we pulse afterward.
REQ-032 Bytes A9, 04 with ready handshakes -> get_next once after A9; imm_addr=04; one EXECUTE cycle with src0=4, tgt0=1, we=0000100b; then get_next.
REQ-033 Bytes 85, 02 -> imm_addr=02; EXECUTE src0=1, tgt0=5, we=1000000b.
REQ-034 Byte 00, then EA -> each gives one EXECUTE cycle with we=0, get_next 3 cycles after accept; no OPERAND state.
REQ-035 Byte A9 followed by 4 cycles with instruction_ready=0 -> state held in OPERAND; no we pulse until operand 7F arrives, then imm_addr=7F.
REQ-036 Byte AA, built with and without INSTRUCTION_DECODER_TRANSFER_EN -> with the macro: src0=1, tgt0=2, we[3]=1; without it: no-op.
